// File: rtl/m0_pkg.sv
// Shared definitions for the M0 memory access unit and the SPI frame sequencer.
package m0_pkg;

    localparam int WORD_W = 16;

    localparam logic [6:0] PH_BOUNDARY     = 7'h41;
    localparam logic [6:0] PH_WRAP         = 7'h53;
    localparam logic [6:0] PH_DATA_START   = 7'h20;
    localparam logic [6:0] PH_DATA_END     = 7'h3F;
    localparam logic [6:0] PH_SAMPLE_FIRST = 7'h22;
    localparam logic [6:0] PH_SAMPLE_LAST  = 7'h40;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/m0_shift16.sv
// Serial-in, parallel-out word shift register used to collect MISO read data.
module m0_shift16
    import m0_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              din,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WORD_W-2:0], din};
        end
    end

endmodule

// File: rtl/m0_mem_access.sv
// Memory access unit: owns one word transaction per SPI frame, serialises
// address/write data toward the sequencer and collects read data from MISO.
module m0_mem_access
    import m0_pkg::*;
#(
    parameter logic [WORD_W-1:0] DUMMY_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        spi_phase,
    input  logic              spi_miso,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              ad_bit,
    output logic              a15,
    output logic              rd_nwr,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata
);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] txn_addr;
    logic [WORD_W-1:0] txn_wdata;
    logic              txn_we;
    logic              txn_real;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] shift_q;
    logic              boundary;
    logic              in_range;
    logic              sample_en;
    logic              complete_read;
    logic [3:0]        bit_idx;

    m0_shift16 u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (sample_en),
        .din      (spi_miso),
        .q        (shift_q)
    );

    // Completion of the old frame and acceptance of the next share the boundary cycle.
    always_comb begin
        in_range      = (spi_phase <= PH_WRAP);
        boundary      = (spi_phase == PH_BOUNDARY);
        req_ready     = boundary && rst_n;
        rsp_valid     = req_ready && (state == ACTIVE) && txn_real;
        complete_read = rsp_valid && !txn_we;
        sample_en     = rst_n && in_range && !spi_phase[0] &&
                        (spi_phase >= PH_SAMPLE_FIRST) && (spi_phase <= PH_SAMPLE_LAST);
        state_next    = state;
        if (req_ready) begin
            state_next = ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each bit is held for two phases; address bit 15 never goes on the wire.
    always_comb begin
        bit_idx = 4'hF - spi_phase[4:1];
        ad_bit  = 1'b0;
        if (rst_n) begin
            if (spi_phase < PH_DATA_START) begin
                ad_bit = (bit_idx == 4'hF) ? 1'b0 : txn_addr[bit_idx];
            end else if (spi_phase <= PH_DATA_END) begin
                ad_bit = txn_we && txn_wdata[bit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_addr  <= '0;
            txn_wdata <= '0;
            txn_we    <= 1'b0;
            txn_real  <= 1'b0;
            rdata_q   <= '0;
        end else if (boundary) begin
            if (complete_read) begin
                rdata_q <= shift_q;
            end
            if (req_valid) begin
                txn_addr  <= req_addr;
                txn_wdata <= req_wdata;
                txn_we    <= req_we;
                txn_real  <= 1'b1;
            end else begin
                txn_addr  <= DUMMY_ADDR;
                txn_wdata <= '0;
                txn_we    <= 1'b0;
                txn_real  <= 1'b0;
            end
        end
    end

    // The completing read word is forwarded so it appears alongside rsp_valid.
    assign rsp_rdata = complete_read ? shift_q : rdata_q;
    assign a15       = txn_addr[WORD_W-1];
    assign rd_nwr    = !txn_we;

endmodule

// File: tb/tb_m0_mem_access.sv
// Randomised bench for m0_mem_access against a frame-level reference model.
module tb_m0_mem_access;

    localparam logic [15:0] DUMMY = 16'h5A3C;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  spi_phase;
    logic        spi_miso;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_we;
    logic [15:0] req_wdata;
    logic        ad_bit;
    logic        a15;
    logic        rd_nwr;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    int vectors     = 0;
    int miscompares = 0;

    req_t        cpu_q[$];
    int          cur_phase;
    int          oor_pct;
    int          rst_cnt;
    bit          rand_mode;
    bit          pat_en;
    logic [15:0] pat_word;

    logic        m_active;
    logic        m_real;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic [15:0] m_cap;

    m0_mem_access #(.DUMMY_ADDR(DUMMY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_phase (spi_phase),
        .spi_miso  (spi_miso),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .ad_bit    (ad_bit),
        .a15       (a15),
        .rd_nwr    (rd_nwr),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h (phase %h, t=%0t)",
                     tag, observed, expected, spi_phase, $time);
        end
    endtask

    function automatic logic expAdBit();
        int p;
        int a;
        p = int'(spi_phase);
        if (!rst_n || p > 63) return 1'b0;
        if (p < 32) begin
            a = int'(m_addr & 16'h7FFF);
            return ((a >> (15 - p / 2)) & 1) == 1;
        end
        if (!m_we) return 1'b0;
        a = int'(m_wdata);
        return ((a >> (15 - (p - 32) / 2)) & 1) == 1;
    endfunction

    task automatic checkCycle();
        logic exp_ready;
        logic exp_valid;
        exp_ready = rst_n && (spi_phase == 7'h41);
        exp_valid = exp_ready && m_active && m_real;
        checkOutput("req_ready", 16'(req_ready), 16'(exp_ready));
        checkOutput("rsp_valid", 16'(rsp_valid), 16'(exp_valid));
        checkOutput("rsp_rdata", rsp_rdata, (exp_valid && !m_we) ? m_cap : m_rdata);
        checkOutput("ad_bit", 16'(ad_bit), 16'(expAdBit()));
        checkOutput("a15", 16'(a15), 16'(m_addr[15]));
        checkOutput("rd_nwr", 16'(rd_nwr), 16'(!m_we));
    endtask

    // Frame-level model: one transaction per frame, read word = the 16 sampled MISO bits.
    task automatic modelUpdate();
        int p;
        p = int'(spi_phase);
        if (!rst_n) begin
            m_active = 1'b0;
            m_real   = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata  = '0;
            m_cap    = '0;
        end else begin
            if (p >= 34 && p <= 64 && (p % 2) == 0) m_cap[15 - (p - 34) / 2] = spi_miso;
            if (p == 65) begin
                if (m_active && m_real && !m_we) m_rdata = m_cap;
                m_active = 1'b1;
                if (req_valid) begin
                    m_real  = 1'b1;
                    m_addr  = req_addr;
                    m_we    = req_we;
                    m_wdata = req_wdata;
                    cpu_q.delete(0);
                end else begin
                    m_real  = 1'b0;
                    m_addr  = DUMMY;
                    m_we    = 1'b0;
                    m_wdata = '0;
                end
            end
        end
    endtask

    task automatic driveReq();
        if (cpu_q.size() > 0) begin
            req_valid = 1'b1;
            req_addr  = cpu_q[0].addr;
            req_we    = cpu_q[0].we;
            req_wdata = cpu_q[0].wdata;
        end else begin
            req_valid = 1'b0;
            req_addr  = 16'($urandom);
            req_we    = 1'($urandom);
            req_wdata = 16'($urandom);
        end
    endtask

    task automatic applyStimulus();
        int p;
        req_t r;
        if (rand_mode) begin
            if (rst_cnt > 0) begin
                rst_n = 1'b0;
                rst_cnt--;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 1999) == 0) rst_cnt = int'($urandom_range(1, 2));
            end
        end
        if (oor_pct > 0 && $urandom_range(0, 99) < oor_pct) begin
            spi_phase = 7'(84 + $urandom_range(0, 43));
        end else begin
            cur_phase = (cur_phase == 83) ? 0 : cur_phase + 1;
            spi_phase = 7'(cur_phase);
        end
        p = int'(spi_phase);
        if (pat_en && p >= 34 && p <= 64 && (p % 2) == 0) spi_miso = pat_word[15 - (p - 34) / 2];
        else spi_miso = 1'($urandom);
        if (rand_mode && cpu_q.size() < 2 && $urandom_range(0, 49) == 0) begin
            r.addr  = 16'($urandom);
            r.we    = 1'($urandom);
            r.wdata = 16'($urandom);
            cpu_q.push_back(r);
        end
        driveReq();
    endtask

    task automatic stepCycle();
        #4;
        checkCycle();
        @(posedge clk);
        modelUpdate();
        #1;
        applyStimulus();
    endtask

    task automatic runUntil(input int target, output int steps);
        steps = 0;
        while (int'(spi_phase) != target && steps < 300) begin
            stepCycle();
            steps++;
        end
        if (int'(spi_phase) != target) checkOutput("run_timeout", 16'(spi_phase), 16'(target));
    endtask

    task automatic pushReq(input logic [15:0] addr, input logic we, input logic [15:0] wdata);
        req_t r;
        r.addr  = addr;
        r.we    = we;
        r.wdata = wdata;
        cpu_q.push_back(r);
        driveReq();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        spi_phase = 7'h40;
        cur_phase = 64;
        spi_miso  = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        oor_pct   = 0;
        rst_cnt   = 0;
        rand_mode = 1'b0;
        pat_en    = 1'b0;
        pat_word  = 16'hA5C3;

        @(posedge clk);
        modelUpdate();
        #1;
        applyStimulus();
        #2;
        checkOutput("rst_ready", 16'(req_ready), 16'h0);
        checkOutput("rst_valid", 16'(rsp_valid), 16'h0);
        checkOutput("rst_rdata", rsp_rdata, 16'h0000);
        checkOutput("rst_ad_bit", 16'(ad_bit), 16'h0);
        checkOutput("rst_a15", 16'(a15), 16'h0);
        checkOutput("rst_rd_nwr", 16'(rd_nwr), 16'h1);
        stepCycle();
        rst_n = 1'b1;

        // Write to RAM, accepted at the first boundary after reset.
        pushReq(16'h8123, 1'b1, 16'hBEEF);
        runUntil(65, n);
        #2;
        checkOutput("first_bnd_valid", 16'(rsp_valid), 16'h0);
        checkOutput("first_bnd_ready", 16'(req_ready), 16'h1);
        stepCycle();
        #2;
        checkOutput("wr_a15", 16'(a15), 16'h1);
        checkOutput("wr_rd_nwr", 16'(rd_nwr), 16'h0);
        pat_en = 1'b1;
        pushReq(16'h0040, 1'b0, 16'h0000);
        runUntil(65, n);
        #2;
        checkOutput("wr_latency", 16'(n + 1), 16'd84);
        checkOutput("wr_valid", 16'(rsp_valid), 16'h1);
        checkOutput("wr_rdata_held", rsp_rdata, 16'h0000);

        // ROM read with a fixed MISO pattern, followed by a back-to-back write.
        pushReq(16'h9000, 1'b1, 16'h1234);
        stepCycle();
        #2;
        checkOutput("rd_a15", 16'(a15), 16'h0);
        checkOutput("rd_rd_nwr", 16'(rd_nwr), 16'h1);
        runUntil(65, n);
        #2;
        checkOutput("rd_valid", 16'(rsp_valid), 16'h1);
        checkOutput("rd_rdata", rsp_rdata, 16'hA5C3);
        checkOutput("b2b_ready", 16'(req_ready), 16'h1);
        stepCycle();
        #2;
        checkOutput("b2b_a15", 16'(a15), 16'h1);
        checkOutput("b2b_rd_nwr", 16'(rd_nwr), 16'h0);
        pat_en = 1'b0;

        // Idle frames: the first boundary completes the write, the rest are dummies.
        for (int i = 0; i < 3; i++) begin
            runUntil(65, n);
            #2;
            if (i > 0) checkOutput("idle_valid", 16'(rsp_valid), 16'h0);
            checkOutput("idle_rdata", rsp_rdata, 16'hA5C3);
            stepCycle();
            #2;
            checkOutput("idle_rd_nwr", 16'(rd_nwr), 16'h1);
            checkOutput("idle_a15", 16'(a15), 16'h0);
        end

        // Late request raised mid-frame.
        runUntil(16, n);
        pushReq(16'h7FFF, 1'b0, 16'h0000);
        runUntil(65, n);
        #2;
        checkOutput("late_wait", 16'(n), 16'd49);
        checkOutput("late_ready", 16'(req_ready), 16'h1);
        pushReq(16'h8AAA, 1'b0, 16'h0000);
        stepCycle();
        runUntil(65, n);
        #2;
        checkOutput("late_latency", 16'(n + 1), 16'd84);
        checkOutput("late_valid", 16'(rsp_valid), 16'h1);

        // Reset in the middle of a read frame.
        stepCycle();
        runUntil(48, n);
        rst_n = 1'b0;
        stepCycle();
        #2;
        checkOutput("mid_rst_ad_bit", 16'(ad_bit), 16'h0);
        checkOutput("mid_rst_valid", 16'(rsp_valid), 16'h0);
        checkOutput("mid_rst_a15", 16'(a15), 16'h0);
        checkOutput("mid_rst_rd_nwr", 16'(rd_nwr), 16'h1);
        checkOutput("mid_rst_rdata", rsp_rdata, 16'h0000);
        stepCycle();
        rst_n = 1'b1;
        pushReq(16'hC001, 1'b1, 16'h0F0F);
        runUntil(65, n);
        #2;
        checkOutput("post_rst_valid", 16'(rsp_valid), 16'h0);
        checkOutput("post_rst_ready", 16'(req_ready), 16'h1);
        stepCycle();
        #2;
        checkOutput("post_rst_a15", 16'(a15), 16'h1);
        runUntil(65, n);
        #2;
        checkOutput("post_rst_done", 16'(rsp_valid), 16'h1);

        // Random traffic with out-of-range phases and occasional resets.
        rand_mode = 1'b1;
        oor_pct   = 5;
        for (int f = 0; f < 40; f++) begin
            runUntil(65, n);
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m0_mem_access.md
# m0_mem_access

Memory access unit for the M0 core: sits between the CPU execution logic and the SPI frame sequencer. It accepts one word read/write request per SPI frame, drives the per-phase serial address/data bit, the chip-select address bit and the read/write command bit into the sequencer, and deserialises MISO read data into a response word. One SPI frame is the 84-phase sequence 0x41…0x53, 0x00…0x40 produced by the sequencer's phase counter.

## Interface
- `DUMMY_ADDR`, default 16'h0000: address used for idle frames, which are filler reads.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active low.
- `spi_phase` in 7: sequencer phase counter, 0x00–0x53.
- `spi_miso` in 1: SPI target output.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: request accepted this cycle.
- `req_addr` in 16: word address.
- `req_we` in 1: 1 = write, 0 = read.
- `req_wdata` in 16: write data.
- `ad_bit` out 1: serial address/data bit to the sequencer's MOSI mux.
- `a15` out 1: selects the chip. 0 = ROM/CS0, 1 = RAM/CS1.
- `rd_nwr` out 1: command bit. 1 = read, 0 = write.
- `rsp_valid` out 1: single-cycle completion pulse.
- `rsp_rdata` out 16: last read word. Holds its value until the next read completes.

## Operation
- States:
  - IDLE: after reset; no frame owned.
  - ACTIVE: a real or dummy transaction owns the current frame.
- Frame boundary is the cycle with `spi_phase == 0x41`. Transaction latching happens only there.
- Accepting a request at the boundary:
  - `req_ready` = (`spi_phase == 0x41`) && `rst_n`. It is combinational and high for exactly that cycle.
  - If `req_valid` is also high, latch addr, we and wdata, and mark the frame real.
  - Otherwise latch `DUMMY_ADDR` as a read and mark the frame dummy.
- `a15` and `rd_nwr` are registered from the latched transaction. They change only at the boundary and are stable for the whole frame.
- `ad_bit` is combinational from `spi_phase` and the latched transaction:
  - Phases 0x00–0x1F: address bit index 15−`spi_phase[4:1]`, MSB first. Bit 15 is sent as 0, since each chip is 32K words.
  - Phases 0x20–0x3F, write frame: `wdata` bit index 15−`spi_phase[4:1]`.
  - Phases 0x20–0x3F, read frame: 0.
  - All other phases: 0.
- Read capture:
  - On even phases 0x22, 0x24, …, 0x40, shift `spi_miso` into a 16-bit shift register, MSB first. That is 16 samples.
  - At the next boundary (0x41), a real read frame copies the shift register into `rsp_rdata`.
- Completion:
  - `rsp_valid` pulses in the boundary cycle that ends a real frame, for reads and for writes.
  - Write completion leaves `rsp_rdata` unchanged.
  - Dummy frames produce no pulse.
- Same-cycle completion and acceptance: one boundary cycle can complete the old transaction (`rsp_valid`) and accept the next (`req_ready`). Back-to-back throughput is one word per 84 clocks.
- The first boundary after reset has no frame to complete, so `rsp_valid` stays 0 there.
- Reset behaviour:
  - Reset mid-frame discards the transaction. No `rsp_valid` is produced for it. State returns to IDLE.
  - Reset values: `ad_bit` 0, `a15` 0, `rd_nwr` 1, `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0x0000, shift register 0.
- Out-of-range `spi_phase` (0x54–0x7F): `ad_bit` = 0; no sampling and no latching.

## Timing
- Request-to-completion latency is 84 clocks, measured boundary to boundary.
- A `req_valid` raised mid-frame waits up to 83 clocks for the next boundary.
- The request fields are sampled only in the `req_ready` cycle. The CPU may change them on the following cycle.
- `ad_bit` has zero added latency relative to `spi_phase`; the sequencer registers it.
- The `rsp_rdata` update and the `rsp_valid` pulse occur in the same cycle. Both are visible on the clock edge after `spi_phase == 0x41` is sampled.

## Structure
- Package `m0_pkg` holds:
  - Phase constants: `PH_BOUNDARY` = 0x41, `PH_WRAP` = 0x53, `PH_DATA_START` = 0x20, `PH_DATA_END` = 0x3F, `PH_SAMPLE_FIRST` = 0x22, `PH_SAMPLE_LAST` = 0x40.
  - The state enum {IDLE, ACTIVE}.
  - The word width constant 16.
- This is shared with the sequencer.
- One sub-module, `m0_shift16`: a 16-bit serial-in, parallel-out shift register with shift enable. It holds the MISO capture.

## Test plan
- Write to RAM: `req_addr` 0x8123, `req_we` 1, `req_wdata` 0xBEEF, accepted at a boundary. Required: `a15` 1 and `rd_nwr` 0 for the frame; `ad_bit` over phases 0x00–0x1F is the bits of 0x0123 MSB first, each held 2 phases; over 0x20–0x3F it is 0xBEEF; `rsp_valid` pulses after 84 clocks; `rsp_rdata` unchanged.
- Read from ROM: `req_addr` 0x0040, `req_we` 0, with MISO driving 0xA5C3 at the even phases 0x22–0x40. Required: `a15` 0, `rd_nwr` 1; `rsp_rdata` = 0xA5C3 together with `rsp_valid` at the next 0x41.
- Idle: `req_valid` low across 3 frames. Required: `rd_nwr` 1, `a15` 0, address bits = `DUMMY_ADDR`, `rsp_valid` never asserted, `rsp_rdata` held.
- Late request: `req_valid` raised at phase 0x10. Required: `req_ready` stays low until phase 0x41, then is high for one cycle; the request completes 84 clocks later.
- Back-to-back: a read, then a write presented at the completion boundary. Required: `rsp_valid` and `req_ready` are both high in the same cycle, and the write's `a15`/`rd_nwr` appear on the next clock.
- Reset mid-read: `rst_n` low at phase 0x30 for 2 cycles. Required: outputs go to their reset values, no `rsp_valid` ever appears for the aborted read, and the next boundary accepts normally.
